// File: rtl/reg_dump_if.sv
// -----------------------------------------------------------------------------
// reg_dump_if -- output word stream of the register-file dumper.
//
// Signals:
//   out_data  [31:0]  dumped word (register contents or checksum)
//   out_index [5:0]   register number of out_data, 32 = checksum word
//   out_valid         out_data/out_index/out_last are valid
//   out_ready         downstream accepts the word when high with out_valid
//   out_last          marks the final word of the dump
//
// Modports:
//   master  -- the dumper (drives the word, samples out_ready)
//   slave   -- the consumer (samples the word, drives out_ready)
// -----------------------------------------------------------------------------
interface reg_dump_if;
  logic [31:0] out_data;
  logic [5:0]  out_index;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    output out_data,
    output out_index,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_index,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/reg_dump.sv
// -----------------------------------------------------------------------------
// reg_dump -- walks all 32 entries of a register file through its combinational
// read port and streams them out with a valid/ready handshake, one word at a
// time, in index order. Optionally appends an XOR checksum of every accepted
// word as a 33rd word (index 32).
//
// Configuration macro:
//   REG_DUMP_CHECKSUM_EN  defined   -> 33-word dump, checksum word carries out_last
//                         undefined -> 32-word dump, register 31 carries out_last
//
// Ports:
//   clock    in   sole clock, all state updates on posedge
//   reset    in   synchronous active-high reset, aborts any dump (no done pulse)
//   start    in   request a full dump; honoured only while idle
//   rf_addr  out  [4:0]  register-file read address
//   rf_data  in   [31:0] combinational read data for rf_addr
//   out_if   master modport of reg_dump_if (out_data/out_index/out_valid/
//                 out_ready/out_last)
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
module reg_dump (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [4:0]        rf_addr,
  input  logic [31:0]       rf_data,
  reg_dump_if.master        out_if,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
`ifdef REG_DUMP_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  localparam logic [4:0] LAST_REG = 5'd31;

  state_t      state_q,     state_d;
  logic [4:0]  rf_addr_q,   rf_addr_d;
  logic [31:0] out_data_q,  out_data_d;
  logic [5:0]  out_index_q, out_index_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q,  out_last_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [31:0] csum_q,      csum_d;
`endif

  logic accept;
  assign accept = out_valid_q && out_if.out_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rf_addr_q   <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rf_addr_q   <= rf_addr_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rf_addr_d   = rf_addr_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rf_addr_d = '0;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d    = '0;
`endif
          state_d   = S_LOAD;
        end
      end

      // Capture the read port for the current address into the output word.
      S_LOAD: begin
        out_data_d  = rf_data;
        out_index_d = {1'b0, rf_addr_q};
        out_valid_d = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = (rf_addr_q == LAST_REG);
`endif
        state_d     = S_SEND;
      end

      // Word held stable until accepted; rf_addr saturates at 31.
      S_SEND: begin
        if (accept) begin
          out_valid_d = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d      = csum_q ^ out_data_q;
`endif
          if (rf_addr_q != LAST_REG) begin
            rf_addr_d = rf_addr_q + 5'd1;
            state_d   = S_LOAD;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            state_d   = S_CSUM;
`else
            state_d   = S_DONE;
`endif
          end
        end
      end

`ifdef REG_DUMP_CHECKSUM_EN
      // Checksum word is presented directly from csum_q (see output mux);
      // out_ready alone completes the handshake here.
      S_CSUM: begin
        if (out_if.out_ready) begin
          state_d = S_DONE;
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    out_if.out_data  = out_data_q;
    out_if.out_index = out_index_q;
    out_if.out_valid = out_valid_q;
    out_if.out_last  = out_last_q;
`ifdef REG_DUMP_CHECKSUM_EN
    if (state_q == S_CSUM) begin
      out_if.out_data  = csum_q;
      out_if.out_index = 6'd32;
      out_if.out_valid = 1'b1;
      out_if.out_last  = 1'b1;
    end
`endif
  end

  assign rf_addr = rf_addr_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);

endmodule
